ifetch_prefetch_tlul: RTL

Instruction-fetch prefetch buffer that sits directly upstream of the instruction memory top. It translates the core's fetch interface into TL-UL Get requests on a host port. It keeps up to `Outstanding` sequential word reads in flight and buffers the returned words in a small FIFO. On a redirect (branch or jump) it flushes the buffer and drops responses that are still in flight.

---
 rtl/tlul_pkg.sv | 34 +++
 rtl/ifetch_prefetch_tlul_if.sv | 12 +
 rtl/ifetch_prefetch_tlul.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// TL-UL channel bundles shared by hosts and devices.
// Trimmed to the fields the fetch path drives and reads.
package tlul_pkg;

   localparam logic [2:0] Get = 3'h4;
   localparam logic [2:0] AccessAckData = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [7:0]  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [7:0]  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/ifetch_prefetch_tlul_if.sv
// TL-UL host port of the fetch prefetcher.
// Member names keep the request/response channel names of the block.
interface ifetch_prefetch_tlul_if;
   import tlul_pkg::*;

   tl_h2d_t tl_h_o;
   tl_d2h_t tl_h_i;

   modport master (output tl_h_o, input tl_h_i);
   modport slave  (input tl_h_o, output tl_h_i);

endinterface

// File: rtl/ifetch_prefetch_tlul.sv
// Sequential instruction prefetcher issuing TL-UL Gets into a small FIFO.
// Redirects flush the FIFO and discard responses still in flight.
module ifetch_prefetch_tlul
   import tlul_pkg::*;
#(
   parameter int unsigned Depth       = 2,
   parameter int unsigned Outstanding = 2,
   parameter logic [31:0] BootAddr    = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   ifetch_prefetch_tlul_if.master tl
);

   localparam int unsigned CW = $clog2(Depth + 1);
   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned QW =
      (Outstanding > 1) ? $clog2(Outstanding) : 1;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
      logic        err;
   } ent_t;

   logic [31:0]   pc_q;
   logic [CW-1:0] inflight_q;
   logic [CW-1:0] discard_q;
   logic [CW-1:0] count_q;
   logic [1:0]    src_q;
   logic [31:0]   aq_q [Outstanding];
   logic [QW-1:0] aq_wr_q;
   logic [QW-1:0] aq_rd_q;
   ent_t          fifo_q [Depth];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;

   logic          a_valid;
   logic          a_fire;
   logic          d_fire;
   logic          push;
   logic          pop;
   logic [CW:0]   pending;
   logic [CW-1:0] inflight_nx;
   logic          unused_bits;

   function automatic logic [QW-1:0] qnext(
      input logic [QW-1:0] p
   );
      return (p == QW'(Outstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // Words already owned by the FIFO or on their way into it.
   assign pending = {1'b0, inflight_q - discard_q}
                  + {1'b0, count_q};

   assign a_valid = reset && !redirect_i
                 && inflight_q < CW'(Outstanding)
                 && pending < (CW + 1)'(Depth);

   assign a_fire = a_valid && tl.tl_h_i.a_ready;
   assign d_fire = tl.tl_h_i.d_valid && inflight_q != '0;
   assign push   = d_fire && !redirect_i && discard_q == '0;
   assign pop    = valid_o && ready_i && !redirect_i;

   assign inflight_nx = inflight_q + CW'(a_fire) - CW'(d_fire);

   always_comb begin
      tl.tl_h_o           = '0;
      tl.tl_h_o.a_valid   = a_valid;
      tl.tl_h_o.a_opcode  = Get;
      tl.tl_h_o.a_size    = 2'd2;
      tl.tl_h_o.a_mask    = 4'hF;
      tl.tl_h_o.a_address = pc_q;
      tl.tl_h_o.a_source  = {6'b0, src_q};
      tl.tl_h_o.d_ready   = 1'b1;
   end

   assign valid_o = count_q != '0;
   assign rdata_o = fifo_q[rd_q].data;
   assign addr_o  = fifo_q[rd_q].addr;
   assign err_o   = fifo_q[rd_q].err;

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q       <= BootAddr;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         src_q      <= '0;
         aq_wr_q    <= '0;
         aq_rd_q    <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         inflight_q <= inflight_nx;
         if (a_fire) begin
            pc_q          <= pc_q + 32'd4;
            aq_q[aq_wr_q] <= pc_q;
            aq_wr_q       <= qnext(aq_wr_q);
            src_q         <= (src_q == 2'(Outstanding - 1))
                           ? 2'd0 : src_q + 2'd1;
         end
         if (d_fire) begin
            aq_rd_q <= qnext(aq_rd_q);
         end
         if (push) begin
            fifo_q[wr_q] <= {tl.tl_h_i.d_data,
                             aq_q[aq_rd_q],
                             tl.tl_h_i.d_error};
            wr_q         <= wr_q + 1'b1;
         end
         // A response landing in the redirect cycle is already excluded.
         if (redirect_i) begin
            pc_q      <= {redirect_addr_i[31:2], 2'b00};
            discard_q <= inflight_nx;
            count_q   <= '0;
            rd_q      <= wr_q;
         end else begin
            if (d_fire && discard_q != '0) begin
               discard_q <= discard_q - 1'b1;
            end
            if (pop) begin
               rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
         end
      end
   end

   assign unused_bits = ^{tl.tl_h_i.d_opcode,
                          tl.tl_h_i.d_param,
                          tl.tl_h_i.d_size,
                          tl.tl_h_i.d_source,
                          tl.tl_h_i.d_sink,
                          tl.tl_h_i.d_user,
                          redirect_addr_i[1:0]};

   d_valid_needs_request: assert property (
      @(posedge clock) disable iff (!reset)
      !(tl.tl_h_i.d_valid && inflight_q == '0)
   );

endmodule
